mod_updown_counter: RTL and testbench



---
 rtl/mod_updown_counter.sv | 108 ++++++++++
 tb/tb_mod_updown_counter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mod_updown_counter: modulo-N up/down counter with enable, prescaler,       |
// | synchronous clear, clamped parallel load and wrap-or-saturate mode.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mod_updown_counter #(
  parameter int BITS     = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            up_dn,
  input  logic            clr,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  output logic [BITS-1:0] Q,
  output logic            tc,
  output logic            wrap,
  output logic            sat
);

  localparam int              c_ps_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [BITS-1:0] c_max     = BITS'(MOD - 1);
  localparam logic [BITS:0]   c_mod     = (BITS + 1)'(MOD);
  localparam logic [c_ps_w-1:0] c_ps_last = c_ps_w'(PRESCALE - 1);

  if (MOD < 2 || longint'(MOD) > (longint'(1) << BITS) || PRESCALE < 1) begin : g_param_check
    $error("mod_updown_counter: illegal MOD/PRESCALE for the chosen BITS");
  end

  logic [BITS-1:0]   q_q, q_d;
  logic [c_ps_w-1:0] ps_q, ps_d;
  logic              wrap_q, wrap_d;
  logic              sat_q, sat_d;
  logic              step;
  logic [BITS-1:0]   load_clamped;

  // Compare one bit wider so MOD == 2**BITS never truncates.
  assign load_clamped = ({1'b0, load_val} >= c_mod) ? c_max : load_val;

  always_comb begin
    q_d    = q_q;
    ps_d   = ps_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    step   = 1'b0;
    if (clr) begin
      q_d   = '0;
      ps_d  = '0;
      sat_d = 1'b0;
    end else if (load) begin
      q_d   = load_clamped;
      ps_d  = '0;
      sat_d = 1'b0;
    end else if (en) begin
      step = (ps_q == c_ps_last);
      ps_d = step ? '0 : ps_q + 1'b1;
      if (step) begin
        if (up_dn) begin
          if (q_q != c_max) begin
            q_d   = q_q + 1'b1;
            sat_d = 1'b0;
          end else if (SATURATE != 0) begin
            sat_d = 1'b1;
          end else begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end else begin
          if (q_q != '0) begin
            q_d   = q_q - 1'b1;
            sat_d = 1'b0;
          end else if (SATURATE != 0) begin
            sat_d = 1'b1;
          end else begin
            q_d    = c_max;
            wrap_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      ps_q   <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      ps_q   <= ps_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign Q    = q_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;
  assign tc   = up_dn ? (q_q == c_max) : (q_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// Testbench for mod_updown_counter: four differently parameterised instances
// share stimulus and are checked against an arithmetic reference model.
module tb_mod_updown_counter;

  localparam int N = 4;
  localparam int MODS [N] = '{10, 10, 10, 16};
  localparam int SATS [N] = '{0, 1, 0, 0};
  localparam int PRES [N] = '{1, 1, 3, 1};

  logic       clk = 1'b0;
  logic       reset, en, up_dn, clr, load;
  logic [3:0] load_val;
  logic [3:0] dq [N];
  logic       dtc [N];
  logic       dwrap [N];
  logic       dsat [N];

  int m_q [N];
  int m_ps [N];
  int m_wrap [N];
  int m_sat [N];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.BITS(4), .MOD(10), .SATURATE(0), .PRESCALE(1)) u_wrap10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Q(dq[0]), .tc(dtc[0]), .wrap(dwrap[0]), .sat(dsat[0]));
  mod_updown_counter #(.BITS(4), .MOD(10), .SATURATE(1), .PRESCALE(1)) u_sat10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Q(dq[1]), .tc(dtc[1]), .wrap(dwrap[1]), .sat(dsat[1]));
  mod_updown_counter #(.BITS(4), .MOD(10), .SATURATE(0), .PRESCALE(3)) u_ps3 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Q(dq[2]), .tc(dtc[2]), .wrap(dwrap[2]), .sat(dsat[2]));
  mod_updown_counter #(.BITS(4), .MOD(16), .SATURATE(0), .PRESCALE(1)) u_full16 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .Q(dq[3]), .tc(dtc[3]), .wrap(dwrap[3]), .sat(dsat[3]));

  // Reference behaviour of one clock edge, written from the counting rules.
  function automatic void model_edge();
    for (int i = 0; i < N; i++) begin
      if (reset || clr) begin
        m_q[i] = 0; m_ps[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
      end else if (load) begin
        m_q[i] = (int'(load_val) >= MODS[i]) ? MODS[i] - 1 : int'(load_val);
        m_ps[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
      end else begin
        m_wrap[i] = 0;
        if (en) begin
          m_ps[i] = m_ps[i] + 1;
          if (m_ps[i] == PRES[i]) begin
            int nxt;
            m_ps[i] = 0;
            nxt = up_dn ? m_q[i] + 1 : m_q[i] - 1;
            if (nxt >= 0 && nxt < MODS[i]) begin
              m_q[i] = nxt; m_sat[i] = 0;
            end else if (SATS[i] != 0) begin
              m_sat[i] = 1;
            end else begin
              m_q[i] = (nxt + MODS[i]) % MODS[i];
              m_wrap[i] = 1;
            end
          end
        end
      end
    end
  endfunction

  function automatic logic exp_tc(int i);
    return up_dn ? (m_q[i] == MODS[i] - 1) : (m_q[i] == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if ({dq[i], dtc[i], dwrap[i], dsat[i]} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset inst%0d: got Q=%0d tc=%b wrap=%b sat=%b, want Q=0 tc=0 wrap=0 sat=0",
                 i, dq[i], dtc[i], dwrap[i], dsat[i]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_up_wrap();
    en = 1'b1; up_dn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_vec++;
        if ({dq[i], dtc[i], dwrap[i], dsat[i]} !== {m_q[i][3:0], exp_tc(i), m_wrap[i][0], m_sat[i][0]}) begin
          n_err++;
          $display("FAIL up_wrap inst%0d cyc%0d: got Q=%0d tc=%b wrap=%b sat=%b, want Q=%0d tc=%b wrap=%b sat=%b",
                   i, c, dq[i], dtc[i], dwrap[i], dsat[i], m_q[i], exp_tc(i), m_wrap[i], m_sat[i]);
        end
      end
    end
  endtask

  task automatic test_down_sat();
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      up_dn = (c == 2);
      tick();
      for (int i = 0; i < N; i++) begin
        n_vec++;
        if ({dq[i], dtc[i], dwrap[i], dsat[i]} !== {m_q[i][3:0], exp_tc(i), m_wrap[i][0], m_sat[i][0]}) begin
          n_err++;
          $display("FAIL down_sat inst%0d cyc%0d: got Q=%0d tc=%b wrap=%b sat=%b, want Q=%0d tc=%b wrap=%b sat=%b",
                   i, c, dq[i], dtc[i], dwrap[i], dsat[i], m_q[i], exp_tc(i), m_wrap[i], m_sat[i]);
        end
      end
      if (c == 0) begin
        n_vec++;
        if ({dq[1], dsat[1], dq[0], dwrap[0]} !== {4'd0, 1'b1, 4'd9, 1'b1}) begin
          n_err++;
          $display("FAIL down_limit: got satQ=%0d sat=%b wrapQ=%0d wrap=%b, want 0 1 9 1",
                   dq[1], dsat[1], dq[0], dwrap[0]);
        end
      end
    end
  endtask

  task automatic test_prescale();
    clr = 1'b1; tick(); clr = 1'b0;
    up_dn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      en = !(c == 4 || c == 5);
      tick();
      n_vec++;
      if ({dq[2], dwrap[2]} !== {m_q[2][3:0], m_wrap[2][0]}) begin
        n_err++;
        $display("FAIL prescale cyc%0d: got Q=%0d wrap=%b, want Q=%0d wrap=%b",
                 c, dq[2], dwrap[2], m_q[2], m_wrap[2]);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_clr_load();
    clr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1;
    tick();
    clr = 1'b0; load_val = 4'd12;
    tick();
    load = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if ({dq[i], dwrap[i], dsat[i]} !== {m_q[i][3:0], m_wrap[i][0], m_sat[i][0]}) begin
        n_err++;
        $display("FAIL clr_load inst%0d: got Q=%0d wrap=%b sat=%b, want Q=%0d wrap=%b sat=%b",
                 i, dq[i], dwrap[i], dsat[i], m_q[i], m_wrap[i], m_sat[i]);
      end
    end
    n_vec++;
    if ({dq[0], dwrap[0], dq[3]} !== {4'd9, 1'b0, 4'd12}) begin
      n_err++;
      $display("FAIL load_clamp: got Q10=%0d wrap=%b Q16=%0d, want 9 0 12", dq[0], dwrap[0], dq[3]);
    end
  endtask

  task automatic test_full_range();
    load = 1'b1; load_val = 4'd15; tick(); load = 1'b0;
    up_dn = 1'b1; en = 1'b1;
    tick();
    n_vec++;
    if ({dq[3], dwrap[3]} !== {4'd0, 1'b1}) begin
      n_err++;
      $display("FAIL full_wrap: got Q=%0d wrap=%b, want Q=0 wrap=1", dq[3], dwrap[3]);
    end
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_vec++;
        if ({dq[i], dwrap[i], dsat[i]} !== {m_q[i][3:0], m_wrap[i][0], m_sat[i][0]}) begin
          n_err++;
          $display("FAIL reset_mid inst%0d cyc%0d: got Q=%0d wrap=%b sat=%b, want Q=%0d wrap=%b sat=%b",
                   i, c, dq[i], dwrap[i], dsat[i], m_q[i], m_wrap[i], m_sat[i]);
        end
      end
    end
  endtask

  task automatic test_toggle();
    load = 1'b1; load_val = 4'd4; tick(); load = 1'b0;
    en = 1'b1; up_dn = 1'b0;
    for (int c = 0; c < 6; c++) begin
      up_dn = ~up_dn;
      #1;
      for (int i = 0; i < N; i++) begin
        n_vec++;
        if (dtc[i] !== exp_tc(i)) begin
          n_err++;
          $display("FAIL toggle_tc inst%0d cyc%0d: got tc=%b, want tc=%b", i, c, dtc[i], exp_tc(i));
        end
      end
      tick();
      n_vec++;
      if (dq[0] !== ((c % 2 == 0) ? 4'd5 : 4'd4)) begin
        n_err++;
        $display("FAIL toggle_q cyc%0d: got Q=%0d, want Q=%0d", c, dq[0], (c % 2 == 0) ? 5 : 4);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 49) == 0);
      clr      = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 2) != 0) ^ (c >= 200);
      tick();
      for (int i = 0; i < N; i++) begin
        n_vec++;
        if ({dq[i], dtc[i], dwrap[i], dsat[i]} !== {m_q[i][3:0], exp_tc(i), m_wrap[i][0], m_sat[i][0]}) begin
          n_err++;
          $display("FAIL random inst%0d cyc%0d: got Q=%0d tc=%b wrap=%b sat=%b, want Q=%0d tc=%b wrap=%b sat=%b",
                   i, c, dq[i], dtc[i], dwrap[i], dsat[i], m_q[i], exp_tc(i), m_wrap[i], m_sat[i]);
        end
      end
    end
    reset = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_q[i] = 0; m_ps[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
    end
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_prescale();
    test_clr_load();
    test_full_range();
    test_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
